// File: rtl/parking_lane_arbiter.sv
// Shared entry/exit barrier lane controller: alternating-priority arbitration,
// open/close sequencing with pass handshake and timeout, authoritative occupancy count.
module parking_lane_arbiter #(
   parameter int CAPACITY    = 50,
   parameter int CNT_W       = 6,
   parameter int OPEN_CYCLES = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             entry_req,
   input  logic             exit_req,
   input  logic             pass,
   output logic             gate_open,
   output logic             dir,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             timeout
);

   localparam int TMR_W = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CAP_C    = CNT_W'(CAPACITY);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(OPEN_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_OPEN  = 2'd1,
      S_CLOSE = 2'd2
   } state_t;

   state_t             state_q;
   logic               gate_open_q;
   logic               dir_q;
   logic               last_dir_q;
   logic [CNT_W-1:0]   count_q;
   logic [CNT_W-1:0]   count_d;
   logic               full_q;
   logic               empty_q;
   logic               timeout_q;
   logic [TMR_W-1:0]   timer_q;

   logic               entry_ok;
   logic               exit_ok;
   logic               grant_any;
   logic               grant_exit;

   always_comb begin
      entry_ok   = entry_req && (count_q < CAP_C);
      exit_ok    = exit_req && (count_q != '0);
      grant_any  = entry_ok || exit_ok;
      // On contention the side opposite the previous grant wins.
      if (entry_ok && exit_ok) grant_exit = ~last_dir_q;
      else                     grant_exit = exit_ok;
   end

   // Next occupancy; full/empty are derived from it so they move on the same edge.
   always_comb begin
      count_d = count_q;
      if (state_q == S_OPEN && pass) begin
         if (dir_q) count_d = count_q - 1'b1;
         else       count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         gate_open_q <= 1'b0;
         dir_q       <= 1'b0;
         last_dir_q  <= 1'b1;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         timeout_q   <= 1'b0;
         timer_q     <= '0;
      end else begin
         timeout_q <= 1'b0;
         count_q   <= count_d;
         full_q    <= (count_d == CAP_C);
         empty_q   <= (count_d == '0);
         case (state_q)
            S_IDLE: begin
               if (grant_any) begin
                  dir_q       <= grant_exit;
                  last_dir_q  <= grant_exit;
                  gate_open_q <= 1'b1;
                  timer_q     <= '0;
                  state_q     <= S_OPEN;
               end
            end
            S_OPEN: begin
               if (pass) begin
                  gate_open_q <= 1'b0;
                  state_q     <= S_CLOSE;
               end else if (timer_q == TMR_LAST) begin
                  gate_open_q <= 1'b0;
                  timeout_q   <= 1'b1;
                  state_q     <= S_CLOSE;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            S_CLOSE: begin
               state_q <= S_IDLE;
            end
            default: begin
               gate_open_q <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign gate_open = gate_open_q;
   assign dir       = dir_q;
   assign count     = count_q;
   assign full      = full_q;
   assign empty     = empty_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_parking_lane_arbiter.sv
// Directed bench for parking_lane_arbiter: expected per-vehicle outcomes are queued
// when a request is driven and checked when the barrier closes.
module tb_parking_lane_arbiter;

   localparam int CAP = 6;
   localparam int CW  = 3;
   localparam int OC  = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          entry_req = 1'b0;
   logic          exit_req = 1'b0;
   logic          pass = 1'b0;
   logic          gate_open;
   logic          dir;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic          timeout;

   typedef struct {
      logic dir;
      int   cnt;
      logic to;
      int   open;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   model_cnt = 0;
   int   lat;
   logic seen;

   parking_lane_arbiter #(
      .CAPACITY   (CAP),
      .CNT_W      (CW),
      .OPEN_CYCLES(OC)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .entry_req(entry_req),
      .exit_req (exit_req),
      .pass     (pass),
      .gate_open(gate_open),
      .dir      (dir),
      .count    (count),
      .full     (full),
      .empty    (empty),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One vehicle: pass_at is the 0-based OPEN cycle carrying pass, or -1 for none.
   task automatic vehicle(input logic ex, input int pass_at, input logic hold, output int gap);
      exp_t e;
      int   oc;
      if (pass_at >= 0) model_cnt = ex ? model_cnt - 1 : model_cnt + 1;
      e.dir  = ex;
      e.cnt  = model_cnt;
      e.to   = (pass_at < 0);
      e.open = (pass_at < 0) ? OC : pass_at + 1;
      sb.push_back(e);
      if (ex) exit_req = 1'b1;
      else    entry_req = 1'b1;
      gap = 0;
      @(negedge clk);
      while (gate_open !== 1'b1 && gap < 12) begin
         @(negedge clk);
         gap++;
      end
      chk("grant", gate_open, 1);
      oc = 0;
      while (gate_open === 1'b1 && oc < 20) begin
         pass = (oc == pass_at);
         @(negedge clk);
         oc++;
      end
      pass = 1'b0;
      if (!hold) begin
         entry_req = 1'b0;
         exit_req  = 1'b0;
      end
      e = sb.pop_front();
      chk("dir", dir, e.dir);
      chk("count", count, e.cnt);
      chk("full", full, e.cnt == CAP);
      chk("empty", empty, e.cnt == 0);
      chk("timeout", timeout, e.to);
      chk("open_len", oc, e.open);
   endtask

   initial begin
      // Reset held for two edges
      repeat (2) @(negedge clk);
      chk("rst_gate", gate_open, 0);
      chk("rst_dir", dir, 0);
      chk("rst_count", count, 0);
      chk("rst_full", full, 0);
      chk("rst_empty", empty, 1);
      chk("rst_timeout", timeout, 0);
      rst = 1'b1;

      // Empty lot: exit alone is never granted
      exit_req = 1'b1;
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (gate_open !== 1'b0) seen = 1'b1;
      end
      exit_req = 1'b0;
      chk("empty_block", seen, 0);
      chk("empty_flag", empty, 1);

      // Single entry then fill to capacity
      vehicle(1'b0, 0, 1'b0, lat);
      chk("first_lat", lat, 0);
      repeat (CAP - 1) vehicle(1'b0, 0, 1'b0, lat);

      // Full lot: entry alone is never granted
      entry_req = 1'b1;
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (gate_open !== 1'b0) seen = 1'b1;
      end
      entry_req = 1'b0;
      chk("full_block", seen, 0);
      chk("full_flag", full, 1);

      // Exit leaves count 5 with last grant = exit, so contention starts with entry
      vehicle(1'b1, 0, 1'b0, lat);
      entry_req = 1'b1;
      exit_req  = 1'b1;
      vehicle(1'b0, 0, 1'b1, lat);
      chk("regrant_gap0", lat, 1);
      vehicle(1'b1, 0, 1'b1, lat);
      chk("regrant_gap1", lat, 1);
      vehicle(1'b0, 0, 1'b1, lat);
      chk("regrant_gap2", lat, 1);
      vehicle(1'b1, 0, 1'b0, lat);
      chk("regrant_gap3", lat, 1);
      chk("contention_count", count, 5);

      // Timeout: no pass, then pulse must be a single cycle
      vehicle(1'b0, -1, 1'b0, lat);
      @(negedge clk);
      chk("timeout_pulse_end", timeout, 0);

      // Pass on the expiry cycle wins over timeout
      vehicle(1'b0, OC - 1, 1'b0, lat);

      // Down to 4, then reset in the middle of an OPEN phase
      vehicle(1'b1, 0, 1'b0, lat);
      vehicle(1'b1, 0, 1'b0, lat);
      chk("pre_reset_count", count, 4);
      entry_req = 1'b1;
      lat = 0;
      @(negedge clk);
      while (gate_open !== 1'b1 && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      chk("mid_open", gate_open, 1);
      rst = 1'b0;
      entry_req = 1'b0;
      @(negedge clk);
      model_cnt = 0;
      chk("mid_rst_gate", gate_open, 0);
      chk("mid_rst_count", count, model_cnt);
      chk("mid_rst_empty", empty, 1);
      chk("mid_rst_dir", dir, 0);
      rst = 1'b1;
      pass = 1'b1;
      @(negedge clk);
      pass = 1'b0;
      @(negedge clk);
      chk("stale_pass_count", count, model_cnt);
      chk("stale_pass_gate", gate_open, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
